// File: rtl/lane_traffic_pkg.sv
// Shared definitions for the lane traffic generator: FSM states, speed codes
// and helpers that locate a lane/level entry inside the flattened tables.
package lane_traffic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [1:0] SPD_STOP = 2'd0;
  localparam logic [1:0] SPD_SLOW = 2'd1;
  localparam logic [1:0] SPD_NORM = 2'd2;
  localparam logic [1:0] SPD_FAST = 2'd3;

  // Tables are ordered level-major, then lane, so level L occupies one contiguous block
  function automatic int pat_base(input int lvl, input int lane, input int lanes, input int bus_w);
    return ((lvl * lanes) + lane) * bus_w;
  endfunction

  function automatic int spd_base(input int lvl, input int lane, input int lanes);
    return ((lvl * lanes) + lane) * 2;
  endfunction

endpackage

// File: rtl/lane_traffic_gen_lane_shifter.sv
// One circular vehicle lane: holds the lane register, a 2-bit tick divider
// selected by the speed code, and rotates one cell per step.
module lane_traffic_gen_lane_shifter
  import lane_traffic_pkg::*;
#(
  parameter int BUS_W  = 8,
  parameter bit DIR_UP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BUS_W-1:0] pattern,
  input  logic [1:0]       speed,
  input  logic             tick,
  output logic [BUS_W-1:0] lane,
  output logic             step
);

  logic [1:0]       cnt_q;
  logic [BUS_W-1:0] lane_q;
  logic [BUS_W-1:0] rotated;

  // The divider is sampled before it increments, so slow lanes step on the 4th tick
  always_comb begin
    step = 1'b0;
    if (tick) begin
      case (speed)
        SPD_FAST: step = 1'b1;
        SPD_NORM: step = cnt_q[0];
        SPD_SLOW: step = (cnt_q == 2'd3);
        default:  step = 1'b0;
      endcase
    end
  end

  always_comb begin
    rotated = lane_q;
    if (DIR_UP) rotated = {lane_q[BUS_W-2:0], lane_q[BUS_W-1]};
    else        rotated = {lane_q[0], lane_q[BUS_W-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      lane_q <= '0;
    end else if (load) begin
      cnt_q  <= 2'd0;
      lane_q <= pattern;
    end else if (tick) begin
      cnt_q <= cnt_q + 2'd1;
      if (step) lane_q <= rotated;
    end
  end

  assign lane = lane_q;

endmodule

// File: rtl/lane_traffic_gen.sv
// Multi-lane vehicle traffic generator: load/run FSM, shared base prescaler,
// latched level and per-lane pattern/speed selection from the level tables.
module lane_traffic_gen
  import lane_traffic_pkg::*;
#(
  parameter int                              LANES       = 4,
  parameter int                              BUS_W       = 8,
  parameter int                              NVL_W       = 2,
  parameter int                              PRESC_W     = 3,
  parameter logic [LANES-1:0]                DIR_MASK    = 4'b0101,
  parameter logic [LANES*BUS_W*(2**NVL_W)-1:0] PATTERN_TBL = {16{8'h18}},
  parameter logic [2*LANES*(2**NVL_W)-1:0]   SPEED_TBL   = {16{2'd2}}
) (
  input  logic                   LANE_TRAFFIC_GEN_CLOCK,
  input  logic                   LANE_TRAFFIC_GEN_RESET,
  input  logic [NVL_W-1:0]       LANE_TRAFFIC_GEN_NVL_IN,
  input  logic                   LANE_TRAFFIC_GEN_CN_IN,
  input  logic                   LANE_TRAFFIC_GEN_PAUSE_IN,
  output logic [LANES*BUS_W-1:0] LANE_TRAFFIC_GEN_LANES_OUT,
  output logic [LANES-1:0]       LANE_TRAFFIC_GEN_STEP_OUT,
  output logic [NVL_W-1:0]       LANE_TRAFFIC_GEN_NVL_OUT,
  output logic                   LANE_TRAFFIC_GEN_READY_OUT
);

  state_t             state_q;
  state_t             state_d;
  logic [NVL_W-1:0]   lvl_q;
  logic [NVL_W-1:0]   nvl_q;
  logic [PRESC_W-1:0] presc_q;
  logic               load;
  logic               run_active;
  logic               tick;

  always_ff @(posedge LANE_TRAFFIC_GEN_CLOCK or posedge LANE_TRAFFIC_GEN_RESET) begin
    if (LANE_TRAFFIC_GEN_RESET) state_q <= IDLE;
    else                        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (LANE_TRAFFIC_GEN_CN_IN) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  assign load       = (state_q == LOAD);
  assign run_active = (state_q == RUN) && !LANE_TRAFFIC_GEN_PAUSE_IN;
  assign tick       = run_active && (presc_q == {PRESC_W{1'b1}});

  // The visible level only changes on the load edge so it always matches the patterns
  always_ff @(posedge LANE_TRAFFIC_GEN_CLOCK or posedge LANE_TRAFFIC_GEN_RESET) begin
    if (LANE_TRAFFIC_GEN_RESET) begin
      lvl_q   <= '0;
      nvl_q   <= '0;
      presc_q <= '0;
    end else begin
      if ((state_q == RUN) && LANE_TRAFFIC_GEN_CN_IN) lvl_q <= LANE_TRAFFIC_GEN_NVL_IN;
      if (load) begin
        nvl_q   <= lvl_q;
        presc_q <= '0;
      end else if (run_active) begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [BUS_W-1:0] pattern;
    logic [1:0]       speed;

    assign pattern = PATTERN_TBL[pat_base(int'(lvl_q), i, LANES, BUS_W) +: BUS_W];
    assign speed   = SPEED_TBL[spd_base(int'(lvl_q), i, LANES) +: 2];

    lane_traffic_gen_lane_shifter #(
      .BUS_W  (BUS_W),
      .DIR_UP (DIR_MASK[i])
    ) u_lane (
      .clk     (LANE_TRAFFIC_GEN_CLOCK),
      .rst     (LANE_TRAFFIC_GEN_RESET),
      .load    (load),
      .pattern (pattern),
      .speed   (speed),
      .tick    (tick),
      .lane    (LANE_TRAFFIC_GEN_LANES_OUT[i*BUS_W +: BUS_W]),
      .step    (LANE_TRAFFIC_GEN_STEP_OUT[i])
    );
  end

  assign LANE_TRAFFIC_GEN_NVL_OUT   = nvl_q;
  assign LANE_TRAFFIC_GEN_READY_OUT = (state_q == RUN);

endmodule
